// File: rtl/seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul_pkg
//   Shared types and constants for the sequential-multiplier scheduler.
//   sched_state_t   : scheduler FSM encoding (also driven on the debug port)
//   MUL_WIDTH       : operand width of the shared multiplier
//   DEFAULT_NUM_REQ : default requester count
//   DEFAULT_TIMEOUT : default watchdog limit in WAIT cycles
// ---------------------------------------------------------------------------
package seq_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    localparam int MUL_WIDTH       = 16;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/seq_mul_sched_if.sv
// ---------------------------------------------------------------------------
// seq_mul_sched_if
//   Bundles the requester, response and multiplier-side signals of the
//   scheduler.
//
//   Handshakes:
//     req    : transfer from requester i when req_valid[i] & req_ready[i].
//              req_ready is one-hot and only ever asserted in IDLE.
//     resp   : transfer when resp_valid & resp_ready; resp_id, resp_product
//              and resp_err are held stable while resp_valid waits for ready.
//     mul    : mul_start is a single-cycle pulse; operands are held until the
//              result is taken; mul_product is valid while mul_ready is high.
//
//   Modports:
//     slave  : the scheduler side
//     master : the environment (requesters, consumer, multiplier)
// ---------------------------------------------------------------------------
interface seq_mul_sched_if #(
    parameter int NUM_REQ = seq_mul_pkg::DEFAULT_NUM_REQ,
    parameter int WIDTH   = seq_mul_pkg::MUL_WIDTH
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [2*WIDTH-1:0]       resp_product;
    logic                     resp_err;

    logic                     mul_start;
    logic [WIDTH-1:0]         mul_multiplicand;
    logic [WIDTH-1:0]         mul_multiplier;
    logic                     mul_ready;
    logic [2*WIDTH-1:0]       mul_product;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, mul_ready, mul_product,
        output req_ready, resp_valid, resp_id, resp_product, resp_err,
               mul_start, mul_multiplicand, mul_multiplier
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_ready, mul_product,
        input  req_ready, resp_valid, resp_id, resp_product, resp_err,
               mul_start, mul_multiplicand, mul_multiplier
    );

endinterface

// File: rtl/seq_mul_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Searches req starting at index ptr and
//   wrapping at N-1 -> 0; the first set bit wins. The pointer register lives
//   in the parent so this block carries no state.
//
//   Ports:
//     req       in  N    request vector
//     ptr       in  IDW  highest-priority index (must be < N)
//     grant     out N    one-hot winner (all zero when no request)
//     grant_id  out IDW  encoded winner
//     grant_any out 1    at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_any
);

    // Index ptr+off reduced modulo N; correct for non-power-of-two N.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IDW'(sum);
    endfunction

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && req[wrap_add(ptr, k)]) begin
                grant_any = 1'b1;
                grant_id  = wrap_add(ptr, k);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_mul_sched.sv
// ---------------------------------------------------------------------------
// seq_mul_sched
//   Shares one sequential signed multiplier among NUM_REQ requesters.
//   Round-robin grant in IDLE, a one-cycle start pulse in ISSUE, a wait for
//   the multiplier's ready in WAIT (with a watchdog), and a held response in
//   RESP tagged with the owning requester. Only one operation is in flight.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous reset, active low
//     bus        slave modport of seq_mul_sched_if (requests, response,
//                multiplier start/operands/ready/product)
//     dbg_state  out  current FSM state
//
//   Parameters:
//     NUM_REQ  requester count (>= 2)
//     WIDTH    operand width, product is 2*WIDTH
//     TIMEOUT  WAIT cycles before an error response (>= WIDTH+4)
// ---------------------------------------------------------------------------
module seq_mul_sched
    import seq_mul_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    parameter  int WIDTH   = MUL_WIDTH,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_mul_sched_if.slave        bus,
    output sched_state_t          dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t        state, state_n;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     ptr_next;
    logic [ID_W-1:0]     gnt_id;
    logic [NUM_REQ-1:0]  gnt_onehot;
    logic                gnt_any;
    logic                issue_grant;

    logic [ID_W-1:0]     id_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [2*WIDTH-1:0]  prod_q;
    logic                err_q;
    logic [WD_W-1:0]     wd_cnt;

    logic                ready_seen;
    logic                wd_expired;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (gnt_onehot),
        .grant_id  (gnt_id),
        .grant_any (gnt_any)
    );

    // wd_cnt is zero in the first WAIT cycle: a ready still high from the
    // previous operation must not be mistaken for this one's result.
    assign ready_seen = bus.mul_ready && (wd_cnt != '0);
    // wd_cnt holds completed WAIT cycles, so this is the TIMEOUT-th one.
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    assign ptr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    // Next-state logic; grants are suppressed while reset is held.
    always_comb begin
        state_n     = state;
        issue_grant = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_any && rst) begin
                    issue_grant = 1'b1;
                    state_n     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (ready_seen || wd_expired) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            err_q  <= 1'b0;
            wd_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_grant) begin
                        id_q   <= gnt_id;
                        a_q    <= bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
                        b_q    <= bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
                        rr_ptr <= ptr_next;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                end
                S_WAIT: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    // A real result wins over a simultaneous expiry.
                    if (ready_seen) begin
                        prod_q <= bus.mul_product;
                        err_q  <= 1'b0;
                    end else if (wd_expired) begin
                        prod_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready        = issue_grant ? gnt_onehot : '0;
    assign bus.mul_start        = (state == S_ISSUE);
    assign bus.mul_multiplicand = a_q;
    assign bus.mul_multiplier   = b_q;
    assign bus.resp_valid       = (state == S_RESP);
    assign bus.resp_id          = id_q;
    assign bus.resp_product     = prod_q;
    assign bus.resp_err         = err_q;
    assign dbg_state            = state;

endmodule

// File: tb/tb_seq_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_seq_mul_sched
//   Bench for seq_mul_sched with a behavioural sequential multiplier and
//   behavioural requesters. Expected responses are queued when a grant is
//   seen and compared when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_seq_mul_sched;
    import seq_mul_pkg::*;

    localparam int NR  = 4;
    localparam int W   = 16;
    localparam int TO  = 64;
    localparam int IDW = 2;
    localparam int RW  = IDW + 2*W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    sched_state_t dbg_state;

    seq_mul_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    seq_mul_sched #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    int                  mul_lat    = 0;
    bit                  mul_hang   = 1'b0;
    bit                  stale_hold = 1'b0;
    logic signed [W-1:0] m_a, m_b;
    logic                m_busy, m_stale;
    int                  m_cnt;

    // Ready stays high after a result until the next start. With stale_hold
    // it also stays high (old product) for one cycle after the start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mul_ready   <= 1'b0;
            bus.mul_product <= '0;
            m_busy          <= 1'b0;
            m_stale         <= 1'b0;
            m_cnt           <= 0;
            m_a             <= '0;
            m_b             <= '0;
        end else if (bus.mul_start) begin
            m_a     <= bus.mul_multiplicand;
            m_b     <= bus.mul_multiplier;
            m_busy  <= 1'b1;
            m_cnt   <= 0;
            m_stale <= stale_hold;
            if (!stale_hold) bus.mul_ready <= 1'b0;
        end else if (m_busy) begin
            if (m_stale) begin
                m_stale       <= 1'b0;
                bus.mul_ready <= 1'b0;
            end else if (!mul_hang && m_cnt >= mul_lat) begin
                bus.mul_ready   <= 1'b1;
                bus.mul_product <= m_a * m_b;
                m_busy          <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int              n_cmp = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              start_cnt = 0;
    int              resp_cnt = 0;
    int              grant_cyc = 0;
    int              last_resp_cyc = 0;
    int              grant_log[$];
    logic [RW-1:0]   exp_q[$];
    logic [2*W-1:0]  pend_prod[NR];
    logic            pend_err[NR];
    logic [NR-1:0]   hold_mask = '0;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // One clock cycle: sample 2 time units before the rising edge, then
    // return 1 unit after it. Served requesters drop valid after the edge.
    task automatic tick();
        logic [NR-1:0] drop;
        logic [RW-1:0] e_rec;
        int            g;
        drop = '0;
        g    = 0;
        @(negedge clk);
        #3;
        cyc++;
        if (bus.req_ready != '0) begin
            check("grant_onehot", 64'($onehot(bus.req_ready)), 64'd1);
            check("grant_has_valid", 64'(|(bus.req_ready & ~bus.req_valid)), 64'd0);
            for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g = i;
            grant_log.push_back(g);
            grant_cyc = cyc;
            exp_q.push_back({IDW'(g), pend_prod[g], pend_err[g]});
            if (!hold_mask[g]) drop[g] = 1'b1;
        end
        if (bus.mul_start) start_cnt++;
        if (bus.resp_valid && bus.resp_ready) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_unexpected: got id %0d product 0x%0h, expected no response",
                         bus.resp_id, bus.resp_product);
            end else begin
                e_rec = exp_q.pop_front();
                check("resp_id", 64'(bus.resp_id), 64'(e_rec[RW-1 -: IDW]));
                check("resp_product", 64'(bus.resp_product), 64'(e_rec[2*W:1]));
                check("resp_err", 64'(bus.resp_err), 64'(e_rec[0]));
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~drop;
    endtask

    task automatic wait_resp(input int target, input int budget);
        int n;
        n = 0;
        while (resp_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("resp_count", 64'(resp_cnt), 64'(target));
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] p, input logic err);
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        pend_prod[id]        = p;
        pend_err[id]         = err;
    endtask

    task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p, input logic err);
        int r0;
        r0 = resp_cnt;
        set_req(id, a, b, p, err);
        bus.req_valid[id] = 1'b1;
        wait_resp(r0 + 1, 300);
    endtask

    // ---------------- global time bound ----------------
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "bench time bound expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int g0, s0, r0, n;
        logic [IDW-1:0] id_h;
        logic [2*W-1:0] p_h;
        logic           e_h;
        bit             stable;

        tbl[0] = '{0, 16'd3,      16'hFFFB, 32'hFFFFFFF1, 0};
        tbl[1] = '{1, 16'h8000,   16'h8000, 32'h40000000, 3};
        tbl[2] = '{2, 16'h7FFF,   16'h7FFF, 32'h3FFF0001, 0};
        tbl[3] = '{3, 16'h8000,   16'h7FFF, 32'hC0008000, 5};
        tbl[4] = '{1, 16'd0,      16'd12345, 32'h00000000, 1};
        tbl[5] = '{2, 16'hFFFF,   16'hFFFF, 32'h00000001, 0};
        tbl[6] = '{0, 16'd7,      16'd6,    32'h0000002A, 2};
        tbl[7] = '{3, 16'd1234,   16'hFFFE, 32'hFFFFF65C, 0};

        for (int i = 0; i < NR; i++) begin
            pend_prod[i] = '0;
            pend_err[i]  = 1'b0;
        end
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        // ---- reset state ----
        tick();
        bus.req_valid = 4'b0001;
        tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_mul_start", 64'(bus.mul_start), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_id", 64'(bus.resp_id), 64'd0);
        check("rst_resp_product", 64'(bus.resp_product), 64'd0);
        check("rst_multiplicand", 64'(bus.mul_multiplicand), 64'd0);
        check("rst_multiplier", 64'(bus.mul_multiplier), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        bus.req_valid = '0;
        rst = 1'b1;
        tick();

        // ---- table of single-requester operations ----
        for (int i = 0; i < 8; i++) begin
            g0 = grant_log.size();
            s0 = start_cnt;
            mul_lat = tbl[i].lat;
            do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, 1'b0);
            check("tbl_grants", 64'(grant_log.size() - g0), 64'd1);
            check("tbl_grant_id", 64'(grant_log[grant_log.size()-1]), 64'(tbl[i].id));
            check("tbl_starts", 64'(start_cnt - s0), 64'd1);
            check("tbl_latency", 64'(last_resp_cyc - grant_cyc), 64'(4 + tbl[i].lat));
            tick();
        end

        // ---- all requesters held high: round-robin order ----
        mul_lat = 1;
        set_req(0, 16'd2,    16'd3,    32'h00000006, 1'b0);
        set_req(1, 16'hFFFC, 16'd5,    32'hFFFFFFEC, 1'b0);
        set_req(2, 16'd100,  16'hFF9C, 32'hFFFFD8F0, 1'b0);
        set_req(3, 16'd255,  16'd255,  32'h0000FE01, 1'b0);
        g0 = grant_log.size();
        s0 = start_cnt;
        r0 = resp_cnt;
        hold_mask     = 4'hF;
        bus.req_valid = 4'hF;
        n = 0;
        while (grant_log.size() < g0 + 8 && n < 400) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        hold_mask     = '0;
        wait_resp(r0 + 8, 100);
        check("rr_grants", 64'(grant_log.size() - g0), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (g0 + k < grant_log.size())
                check("rr_order", 64'(grant_log[g0+k]), 64'(k % 4));
        end
        check("rr_starts", 64'(start_cnt - s0), 64'd8);
        tick();

        // ---- consumer back-pressure holds the response ----
        mul_lat = 0;
        bus.resp_ready = 1'b0;
        set_req(3, 16'd9, 16'd9, 32'h00000051, 1'b0);
        set_req(0, 16'hFFFD, 16'd4, 32'hFFFFFFF4, 1'b0);
        bus.req_valid[3] = 1'b1;
        tick();
        check("bp_first_grant", 64'(grant_log[grant_log.size()-1]), 64'd3);
        bus.req_valid[0] = 1'b1;
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("bp_resp_id", 64'(bus.resp_id), 64'd3);
        check("bp_resp_product", 64'(bus.resp_product), 64'h51);
        id_h = bus.resp_id;
        p_h  = bus.resp_product;
        e_h  = bus.resp_err;
        g0 = grant_log.size();
        s0 = start_cnt;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!bus.resp_valid || bus.resp_id !== id_h || bus.resp_product !== p_h ||
                bus.resp_err !== e_h) stable = 1'b0;
        end
        check("bp_outputs_stable", 64'(stable), 64'd1);
        check("bp_no_grant", 64'(grant_log.size() - g0), 64'd0);
        check("bp_no_start", 64'(start_cnt - s0), 64'd0);
        r0 = resp_cnt;
        bus.resp_ready = 1'b1;
        tick();
        check("bp_release_handshake", 64'(resp_cnt - r0), 64'd1);
        tick();
        check("bp_grant_next_cycle", 64'(grant_log.size() - g0), 64'd1);
        check("bp_grant_next_id", 64'(grant_log[grant_log.size()-1]), 64'd0);
        wait_resp(r0 + 2, 50);

        // ---- hung multiplier: watchdog error, then recovery ----
        mul_hang = 1'b1;
        do_op(1, 16'd5, 16'd5, 32'h0, 1'b1);
        check("wd_latency", 64'(last_resp_cyc - grant_cyc), 64'(TO + 2));
        mul_hang = 1'b0;
        do_op(2, 16'h8000, 16'h8000, 32'h40000000, 1'b0);

        // ---- stale ready from previous op is ignored ----
        check("stale_ready_present", 64'(bus.mul_ready), 64'd1);
        stale_hold = 1'b1;
        do_op(0, 16'd7, 16'd6, 32'h0000002A, 1'b0);
        stale_hold = 1'b0;

        // ---- asynchronous reset during WAIT ----
        mul_hang = 1'b1;
        set_req(2, 16'd11, 16'd11, 32'h00000079, 1'b0);
        bus.req_valid[2] = 1'b1;
        n = 0;
        while (dbg_state != S_WAIT && n < 20) begin
            tick();
            n++;
        end
        check("arst_in_wait", 64'(dbg_state), 64'(S_WAIT));
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", 64'(dbg_state), 64'(S_IDLE));
        check("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("arst_resp_id", 64'(bus.resp_id), 64'd0);
        check("arst_resp_err", 64'(bus.resp_err), 64'd0);
        check("arst_resp_product", 64'(bus.resp_product), 64'd0);
        check("arst_multiplicand", 64'(bus.mul_multiplicand), 64'd0);
        check("arst_multiplier", 64'(bus.mul_multiplier), 64'd0);
        check("arst_mul_start", 64'(bus.mul_start), 64'd0);
        exp_q.delete();
        bus.req_valid = '0;
        mul_hang = 1'b0;
        s0 = start_cnt;
        tick();
        tick();
        check("arst_no_restart", 64'(start_cnt - s0), 64'd0);
        rst = 1'b1;
        r0 = resp_cnt;
        g0 = grant_log.size();
        set_req(2, 16'd100, 16'd200, 32'h00004E20, 1'b0);
        set_req(3, 16'd1, 16'd1, 32'h00000001, 1'b0);
        bus.req_valid = 4'b1100;
        wait_resp(r0 + 2, 100);
        if (grant_log.size() >= g0 + 2) begin
            check("arst_ptr_first", 64'(grant_log[g0]), 64'd2);
            check("arst_ptr_second", 64'(grant_log[g0+1]), 64'd3);
        end else begin
            check("arst_grants", 64'(grant_log.size() - g0), 64'd2);
        end
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
